// File: rtl/code_sequencer.sv
// Keypad code lock: digit entry, open/auto-relock, code programming and
// brute-force lockout, with a 2-flop synchronised reset release.
module code_sequencer #(
  parameter int          CODE_LEN       = 4,
  parameter logic [15:0] DEFAULT_CODE   = 16'h1234,
  parameter int          MAX_FAILS      = 3,
  parameter int          LOCKOUT_CYCLES = 1000,
  parameter int          OPEN_CYCLES    = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       lock,
  output logic       green,
  output logic       blue,
  output logic       lockout,
  output logic [1:0] fail_count
);

  localparam int          TMAX      = (LOCKOUT_CYCLES > OPEN_CYCLES) ? LOCKOUT_CYCLES : OPEN_CYCLES;
  localparam int          TW        = (TMAX > 1) ? $clog2(TMAX + 1) : 1;
  localparam logic [15:0] CODE_MASK = 16'hFFFF >> (4 * (4 - CODE_LEN));
  localparam logic [2:0]  LEN3      = 3'(CODE_LEN);
  localparam logic [TW-1:0] OPEN_LOAD = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCKOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_OPEN,
    S_PROG,
    S_LOCKOUT
  } state_t;

  state_t        state, state_n;
  logic [15:0]   buffer, buffer_n;
  logic [15:0]   code, code_n;
  logic [2:0]    digit_cnt, digit_cnt_n;
  logic [1:0]    fails_n;
  logic [TW-1:0] timer, timer_n;
  logic          lock_n, green_n, blue_n, lockout_n;

  // Reset asserts immediately but releases only after two clock edges.
  logic [1:0] rst_sync;
  logic       rst_int;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync <= '0;
    else      rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_int = rst_sync[1];

  logic       key_ok, is_digit, code_match, cnt_full;
  logic [1:0] fails_inc;

  assign key_ok     = key_valid && (key_code <= 4'hC);
  assign is_digit   = key_code <= 4'd9;
  assign code_match = ((buffer ^ code) & CODE_MASK) == '0;
  assign cnt_full   = digit_cnt == LEN3;
  assign fails_inc  = (fail_count == 2'd3) ? 2'd3 : fail_count + 2'd1;

  always_ff @(posedge clk or negedge rst_int) begin
    if (!rst_int) begin
      state      <= S_IDLE;
      buffer     <= '0;
      code       <= DEFAULT_CODE;
      digit_cnt  <= '0;
      fail_count <= '0;
      timer      <= '0;
      lock       <= 1'b1;
      green      <= 1'b0;
      blue       <= 1'b0;
      lockout    <= 1'b0;
    end else begin
      state      <= state_n;
      buffer     <= buffer_n;
      code       <= code_n;
      digit_cnt  <= digit_cnt_n;
      fail_count <= fails_n;
      timer      <= timer_n;
      lock       <= lock_n;
      green      <= green_n;
      blue       <= blue_n;
      lockout    <= lockout_n;
    end
  end

  always_comb begin
    state_n     = state;
    buffer_n    = buffer;
    code_n      = code;
    digit_cnt_n = digit_cnt;
    fails_n     = fail_count;
    timer_n     = timer;
    case (state)
      S_IDLE, S_ENTRY: begin
        if (key_ok) begin
          if (is_digit) begin
            buffer_n    = {buffer[11:0], key_code};
            digit_cnt_n = (digit_cnt == 3'd4) ? 3'd4 : digit_cnt + 3'd1;
            state_n     = S_ENTRY;
          end else if (key_code == 4'hA) begin
            buffer_n    = '0;
            digit_cnt_n = '0;
            state_n     = S_IDLE;
          end else if (key_code == 4'hB) begin
            buffer_n    = '0;
            digit_cnt_n = '0;
            if (cnt_full && code_match) begin
              state_n = S_OPEN;
              fails_n = '0;
              timer_n = OPEN_LOAD;
            end else begin
              fails_n = fails_inc;
              if (32'(fails_inc) == 32'(MAX_FAILS)) begin
                state_n = S_LOCKOUT;
                timer_n = LOCK_LOAD;
              end else begin
                state_n = S_IDLE;
              end
            end
          end
        end
      end
      S_OPEN: begin
        // A key arriving on the expiry cycle takes precedence over relock.
        if (key_ok) begin
          timer_n = OPEN_LOAD;
          if (key_code == 4'hB) begin
            state_n = S_IDLE;
          end else if (key_code == 4'hC) begin
            state_n     = S_PROG;
            buffer_n    = '0;
            digit_cnt_n = '0;
          end
        end else if (timer == '0) begin
          state_n = S_IDLE;
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      S_PROG: begin
        if (key_ok) begin
          if (is_digit) begin
            buffer_n    = {buffer[11:0], key_code};
            digit_cnt_n = (digit_cnt == 3'd4) ? 3'd4 : digit_cnt + 3'd1;
          end else if (key_code == 4'hA) begin
            state_n     = S_OPEN;
            buffer_n    = '0;
            digit_cnt_n = '0;
            timer_n     = OPEN_LOAD;
          end else if (key_code == 4'hB) begin
            buffer_n    = '0;
            digit_cnt_n = '0;
            if (cnt_full) begin
              code_n  = buffer;
              state_n = S_OPEN;
              timer_n = OPEN_LOAD;
            end
          end
        end
      end
      S_LOCKOUT: begin
        if (timer == '0) begin
          state_n = S_IDLE;
          fails_n = '0;
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    lock_n    = 1'b1;
    green_n   = 1'b0;
    blue_n    = 1'b0;
    lockout_n = 1'b0;
    case (state_n)
      S_OPEN: begin
        lock_n  = 1'b0;
        green_n = 1'b1;
      end
      S_PROG: begin
        lock_n  = 1'b0;
        green_n = 1'b1;
        blue_n  = 1'b1;
      end
      S_LOCKOUT: lockout_n = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_code_sequencer.sv
// Directed bench for code_sequencer; outputs checked as {lock,green,blue,lockout,fail_count}.
module tb_code_sequencer;

  localparam int L = 16;
  localparam int O = 24;

  logic       clk;
  logic       rst;
  logic       key_valid;
  logic [3:0] key_code;
  logic       lock, green, blue, lockout;
  logic [1:0] fail_count;
  logic [5:0] obs;

  int tests;
  int fails;

  code_sequencer #(
    .CODE_LEN(4),
    .DEFAULT_CODE(16'h1234),
    .MAX_FAILS(3),
    .LOCKOUT_CYCLES(L),
    .OPEN_CYCLES(O)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_valid(key_valid),
    .key_code(key_code),
    .lock(lock),
    .green(green),
    .blue(blue),
    .lockout(lockout),
    .fail_count(fail_count)
  );

  assign obs = {lock, green, blue, lockout, fail_count};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge; key sampled on the next posedge, returns at the following negedge.
  task automatic press(input logic [3:0] c);
    key_valid = 1'b1;
    key_code  = c;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'hB;
  endtask

  task automatic enter(input logic [15:0] c);
    press(c[15:12]);
    press(c[11:8]);
    press(c[7:4]);
    press(c[3:0]);
    press(4'hB);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    key_valid = 1'b0;
    key_code = 4'h0;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (obs !== 6'b100000) begin fails++; $display("FAIL reset_hold: obs=%b exp=%b", obs, 6'b100000); end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (obs !== 6'b100000) begin fails++; $display("FAIL reset_release: obs=%b exp=%b", obs, 6'b100000); end
  endtask

  task automatic test_open();
    enter(16'h1234);
    tests++; if (obs !== 6'b010000) begin fails++; $display("FAIL open_1234: obs=%b exp=%b", obs, 6'b010000); end
    press(4'hB);
    tests++; if (obs !== 6'b100000) begin fails++; $display("FAIL relock: obs=%b exp=%b", obs, 6'b100000); end
  endtask

  task automatic test_lockout();
    press(4'h1); press(4'h2); press(4'h3); press(4'hB);
    tests++; if (obs !== 6'b100001) begin fails++; $display("FAIL fail_1: obs=%b exp=%b", obs, 6'b100001); end
    enter(16'h9999);
    tests++; if (obs !== 6'b100010) begin fails++; $display("FAIL fail_2: obs=%b exp=%b", obs, 6'b100010); end
    press(4'hB);
    tests++; if (obs !== 6'b100111) begin fails++; $display("FAIL lockout_enter: obs=%b exp=%b", obs, 6'b100111); end
    enter(16'h1234);
    tests++; if (obs !== 6'b100111) begin fails++; $display("FAIL lockout_keys_ignored: obs=%b exp=%b", obs, 6'b100111); end
    repeat (L - 6) @(negedge clk);
    tests++; if (obs !== 6'b100111) begin fails++; $display("FAIL lockout_last_cycle: obs=%b exp=%b", obs, 6'b100111); end
    @(negedge clk);
    tests++; if (obs !== 6'b100000) begin fails++; $display("FAIL lockout_expire: obs=%b exp=%b", obs, 6'b100000); end
  endtask

  task automatic test_lockout_edge();
    press(4'hB); press(4'hB); press(4'hB);
    tests++; if (obs !== 6'b100111) begin fails++; $display("FAIL edge_lockout_enter: obs=%b exp=%b", obs, 6'b100111); end
    repeat (L - 1) @(negedge clk);
    press(4'h1);
    tests++; if (obs !== 6'b100000) begin fails++; $display("FAIL edge_expire: obs=%b exp=%b", obs, 6'b100000); end
    press(4'h2); press(4'h3); press(4'h4); press(4'hB);
    tests++; if (obs !== 6'b100001) begin fails++; $display("FAIL edge_key_dropped: obs=%b exp=%b", obs, 6'b100001); end
    enter(16'h1234);
    tests++; if (obs !== 6'b010000) begin fails++; $display("FAIL edge_reopen: obs=%b exp=%b", obs, 6'b010000); end
    press(4'hB);
  endtask

  task automatic test_program();
    enter(16'h1234);
    press(4'hC);
    tests++; if (obs !== 6'b011000) begin fails++; $display("FAIL prog_enter: obs=%b exp=%b", obs, 6'b011000); end
    press(4'h5); press(4'h6); press(4'h7); press(4'h8);
    tests++; if (obs !== 6'b011000) begin fails++; $display("FAIL prog_digits: obs=%b exp=%b", obs, 6'b011000); end
    press(4'hB);
    tests++; if (obs !== 6'b010000) begin fails++; $display("FAIL prog_commit: obs=%b exp=%b", obs, 6'b010000); end
    press(4'hB);
    enter(16'h5678);
    tests++; if (obs !== 6'b010000) begin fails++; $display("FAIL new_code_opens: obs=%b exp=%b", obs, 6'b010000); end
    press(4'hB);
    enter(16'h1234);
    tests++; if (obs !== 6'b100001) begin fails++; $display("FAIL old_code_fails: obs=%b exp=%b", obs, 6'b100001); end
    enter(16'h5678);
    press(4'hC); press(4'h1); press(4'hB);
    tests++; if (obs !== 6'b011000) begin fails++; $display("FAIL prog_short_stays: obs=%b exp=%b", obs, 6'b011000); end
    press(4'h9); press(4'hA);
    tests++; if (obs !== 6'b010000) begin fails++; $display("FAIL prog_abort: obs=%b exp=%b", obs, 6'b010000); end
    press(4'hB);
    enter(16'h5678);
    tests++; if (obs !== 6'b010000) begin fails++; $display("FAIL abort_keeps_code: obs=%b exp=%b", obs, 6'b010000); end
    press(4'hB);
  endtask

  task automatic test_reset_in_prog();
    enter(16'h5678);
    press(4'hC); press(4'h9); press(4'h9);
    tests++; if (obs !== 6'b011000) begin fails++; $display("FAIL prog_partial: obs=%b exp=%b", obs, 6'b011000); end
    rst = 1'b0;
    #1;
    tests++; if (obs !== 6'b100000) begin fails++; $display("FAIL async_reset: obs=%b exp=%b", obs, 6'b100000); end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    enter(16'h1234);
    tests++; if (obs !== 6'b010000) begin fails++; $display("FAIL default_code_restored: obs=%b exp=%b", obs, 6'b010000); end
    press(4'hB);
  endtask

  task automatic test_buffer();
    press(4'h1); enter(16'h2345);
    tests++; if (obs !== 6'b100001) begin fails++; $display("FAIL overflow_fail: obs=%b exp=%b", obs, 6'b100001); end
    press(4'h1); press(4'h2); press(4'hA);
    enter(16'h1234);
    tests++; if (obs !== 6'b010000) begin fails++; $display("FAIL clear_then_open: obs=%b exp=%b", obs, 6'b010000); end
    press(4'hB);
  endtask

  task automatic test_ignore();
    press(4'hC);
    press(4'h1);
    key_code = 4'h5;
    @(negedge clk);
    press(4'hD);
    press(4'h2); press(4'h3); press(4'hF); press(4'h4); press(4'hB);
    tests++; if (obs !== 6'b010000) begin fails++; $display("FAIL invalid_ignored: obs=%b exp=%b", obs, 6'b010000); end
    press(4'hB);
  endtask

  task automatic test_open_timeout();
    enter(16'h1234);
    repeat (O - 1) @(negedge clk);
    tests++; if (obs !== 6'b010000) begin fails++; $display("FAIL open_before_timeout: obs=%b exp=%b", obs, 6'b010000); end
    @(negedge clk);
    tests++; if (obs !== 6'b100000) begin fails++; $display("FAIL open_timeout: obs=%b exp=%b", obs, 6'b100000); end
    enter(16'h1234);
    repeat (O - 2) @(negedge clk);
    press(4'h5);
    repeat (O - 1) @(negedge clk);
    tests++; if (obs !== 6'b010000) begin fails++; $display("FAIL restart_still_open: obs=%b exp=%b", obs, 6'b010000); end
    @(negedge clk);
    tests++; if (obs !== 6'b100000) begin fails++; $display("FAIL restart_timeout: obs=%b exp=%b", obs, 6'b100000); end
    enter(16'h1234);
    repeat (O - 1) @(negedge clk);
    press(4'h5);
    tests++; if (obs !== 6'b010000) begin fails++; $display("FAIL key_wins_expiry: obs=%b exp=%b", obs, 6'b010000); end
    press(4'hB);
    tests++; if (obs !== 6'b100000) begin fails++; $display("FAIL final_relock: obs=%b exp=%b", obs, 6'b100000); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_open();
    test_lockout();
    test_lockout_edge();
    test_program();
    test_reset_in_prog();
    test_buffer();
    test_ignore();
    test_open_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time=%0t limit=%0d", $time, 200000);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/code_sequencer.md
CODE_SEQUENCER -- requirements
Module: code_sequencer

Interface
REQ-001 SHALL have parameter CODE_LEN, default 4: number of digits in a valid code (1..4).
REQ-002 SHALL have parameter DEFAULT_CODE, default 16'h1234: stored code after reset, most recent digit in [3:0].
REQ-003 SHALL have parameter MAX_FAILS, default 3: consecutive wrong codes that trigger lockout.
REQ-004 SHALL have parameter LOCKOUT_CYCLES, default 1000: lockout duration in clk cycles.
REQ-005 SHALL have parameter OPEN_CYCLES, default 5000: idle cycles in OPEN before auto-relock.
REQ-006 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1: reset, asynchronous and active-low.
REQ-008 SHALL have port key_valid, input, 1: one-cycle strobe marking a new keypress.
REQ-009 SHALL have port key_code, input, 4: key value 0-9 digit, 0xA clear, 0xB enter, 0xC program; 0xD-0xF invalid.
REQ-010 SHALL have port lock, output, 1: 1 = bolt engaged.
REQ-011 SHALL have port green, output, 1: 1 = safe open.
REQ-012 SHALL have port blue, output, 1: 1 = programming mode.
REQ-013 SHALL have port lockout, output, 1: 1 = keypad disabled after too many failures.
REQ-014 SHALL have port fail_count, output, 2: consecutive wrong-code count, saturating at 3.

Function
REQ-015 SHALL implement states IDLE, ENTRY, OPEN, PROG and LOCKOUT; all outputs registered and updated one cycle after the key_valid edge that causes the change.
REQ-016 SHALL ignore key_code when key_valid=0, and SHALL ignore invalid codes 0xD-0xF in every state.
REQ-017 In IDLE/ENTRY, a digit SHALL shift into a 4-nibble buffer (new digit to [3:0]) and increment digit_cnt, saturating at 4 (oldest digit dropped); IDLE->ENTRY on the first digit.
REQ-018 In IDLE/ENTRY, 0xA SHALL clear buffer and digit_cnt and go to IDLE; 0xC SHALL be ignored.
REQ-019 In IDLE/ENTRY, 0xB with digit_cnt==CODE_LEN and the low CODE_LEN nibbles equal to the stored code SHALL go to OPEN, clear fail_count and clear the buffer.
REQ-020 Any other 0xB in IDLE/ENTRY SHALL count as a failure: fail_count+1, buffer cleared, state IDLE; if the new count equals MAX_FAILS, go to LOCKOUT and load the timer with LOCKOUT_CYCLES-1.
REQ-021 In OPEN: lock=0, green=1; 0xB SHALL relock to IDLE; 0xC SHALL enter PROG with buffer cleared; a digit or 0xA SHALL be ignored but SHALL restart the idle timer.
REQ-022 OPEN SHALL load the timer with OPEN_CYCLES-1 on entry and on every valid key, decrement otherwise, and go to IDLE the cycle after it reaches 0.
REQ-023 In PROG: blue=1, lock=0, green=1; digits shift as in REQ-017; 0xA SHALL abort to OPEN with the stored code unchanged; 0xC SHALL be ignored.
REQ-024 In PROG, 0xB with digit_cnt==CODE_LEN SHALL write the buffer into the stored code and go to OPEN; 0xB with any other count SHALL clear the buffer and stay in PROG.
REQ-025 In LOCKOUT: lockout=1, lock=1; all keys SHALL be ignored; the timer decrements each cycle; at 0 the state SHALL go to IDLE and fail_count SHALL clear.
REQ-026 If key_valid coincides with LOCKOUT timer expiry, expiry SHALL win and the key SHALL be dropped.
REQ-027 If key_valid coincides with OPEN timer expiry, the key SHALL win and be processed as in OPEN.
REQ-028 In IDLE/ENTRY: lock=1, green=0, blue=0, lockout=0.

Reset
REQ-029 On rst=0, asynchronously: state=IDLE, stored code=DEFAULT_CODE, buffer=0, digit_cnt=0, fail_count=0, timer=0, lock=1, green=0, blue=0, lockout=0.
REQ-030 Reset mid-operation (any state, including PROG with a partial code) SHALL discard all progress; any programmed code SHALL revert to DEFAULT_CODE.
REQ-031 Reset release SHALL be synchronised with a 2-flop chain before it affects state, so that reset deasserts cleanly without metastability.

Verification
REQ-032 Keys 1,2,3,4,0xB -> green=1, lock=0 one cycle after the 0xB strobe; fail_count=0.
REQ-033 Keys 1,2,3,0xB then 9,9,9,9,0xB then 0xB -> fail_count 1,2, then lockout=1; 1,2,3,4,0xB during lockout -> no change; lockout=0 exactly LOCKOUT_CYCLES cycles after entry.
REQ-034 Open, then 0xC,5,6,7,8,0xB -> blue 1 then 0, green=1; 0xB to relock; 5,6,7,8,0xB -> opens; 1,2,3,4,0xB -> fail_count=1.
REQ-035 Keys 1,2,3,4,5,0xB -> buffer holds 2345, failure; 1,2,0xA,1,2,3,4,0xB -> opens.
REQ-036 Open and send no keys -> lock=1 after OPEN_CYCLES cycles; a digit at cycle OPEN_CYCLES-1 -> stays open for a further OPEN_CYCLES cycles.
REQ-037 Assert rst in PROG after 0xC,9,9 -> all outputs at reset values; 1,2,3,4,0xB -> opens.
